// File: rtl/regfile_bridge_pkg.sv
// regfile_bridge_pkg: shared FSM states and response codes for the AXI4-Lite register file bridge
package regfile_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_EXEC,
        WR_RESP,
        RD_EXEC,
        RD_WAIT,
        RD_RESP
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_regfile_bridge.sv
// axil_regfile_bridge: AXI4-Lite slave driving a single-port strobe register file, one transaction at a time
import regfile_bridge_pkg::*;

module axil_regfile_bridge #(
    parameter int Naddr = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [Naddr+1:0] s_axi_awaddr,
    input  logic             s_axi_awvalid,
    output logic             s_axi_awready,
    input  logic [31:0]      s_axi_wdata,
    input  logic [3:0]       s_axi_wstrb,
    input  logic             s_axi_wvalid,
    output logic             s_axi_wready,
    output logic [1:0]       s_axi_bresp,
    output logic             s_axi_bvalid,
    input  logic             s_axi_bready,
    input  logic [Naddr+1:0] s_axi_araddr,
    input  logic             s_axi_arvalid,
    output logic             s_axi_arready,
    output logic [31:0]      s_axi_rdata,
    output logic [1:0]       s_axi_rresp,
    output logic             s_axi_rvalid,
    input  logic             s_axi_rready,
    output logic [Naddr-1:0] rf_addr,
    output logic [31:0]      rf_wr_data,
    input  logic [31:0]      rf_rd_data,
    output logic             rf_en,
    output logic [3:0]       rf_we
);

    state_t state, state_nx;
    logic   last_wr;
    logic   sel_wr, sel_rd;
    logic   unused_lsbs;

    assign unused_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Arbitration: a write needs both address and data; on a tie the side that did not go last wins
    always_comb begin
        sel_rd = (state == IDLE) && s_axi_arvalid && (!(s_axi_awvalid && s_axi_wvalid) || last_wr);
        sel_wr = (state == IDLE) && s_axi_awvalid && s_axi_wvalid && !sel_rd;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = sel_rd ? RD_EXEC : sel_wr ? WR_EXEC : IDLE;
            WR_EXEC: state_nx = WR_RESP;
            WR_RESP: state_nx = s_axi_bready ? IDLE : WR_RESP;
            RD_EXEC: state_nx = RD_WAIT;
            RD_WAIT: state_nx = RD_RESP;
            RD_RESP: state_nx = s_axi_rready ? IDLE : RD_RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs; readies are held low while reset is asserted so no request is acknowledged and lost
    always_comb begin
        s_axi_awready = resetn && sel_wr;
        s_axi_wready  = resetn && sel_wr;
        s_axi_arready = resetn && sel_rd;
        s_axi_bvalid  = (state == WR_RESP);
        s_axi_rvalid  = (state == RD_RESP);
        s_axi_bresp   = AXI_RESP_OKAY;
        s_axi_rresp   = AXI_RESP_OKAY;
    end

    // Register-file strobes launch on acceptance so rf_en is high for exactly the EXEC cycle; read data is captured in RD_WAIT
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_wr     <= 1'b1;
            rf_en       <= 1'b0;
            rf_we       <= 4'h0;
            rf_addr     <= '0;
            rf_wr_data  <= 32'h0;
            s_axi_rdata <= 32'h0;
        end else begin
            rf_en <= sel_wr || sel_rd;
            rf_we <= sel_wr ? s_axi_wstrb : 4'h0;
            if (sel_wr) begin
                last_wr    <= 1'b1;
                rf_addr    <= s_axi_awaddr[Naddr+1:2];
                rf_wr_data <= s_axi_wdata;
            end
            if (sel_rd) begin
                last_wr <= 1'b0;
                rf_addr <= s_axi_araddr[Naddr+1:2];
            end
            if (state == RD_WAIT) s_axi_rdata <= rf_rd_data;
        end
    end

endmodule

// File: tb/tb_axil_regfile_bridge.sv
// tb_axil_regfile_bridge: directed self-checking bench for the AXI4-Lite register file bridge
module tb_axil_regfile_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, rf_en;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, rf_wr_data, rf_rd_data;
    logic [3:0]  rf_addr, rf_we;
    int          compared = 0, mismatched = 0;

    axil_regfile_bridge #(.Naddr(4)) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data),
        .rf_en(rf_en), .rf_we(rf_we)
    );

    always #5 clk = ~clk;

    // Register file model: data is valid only in the cycle right after rf_en, poison otherwise
    always @(posedge clk)
        rf_rd_data <= !rf_en ? 32'hBAD0_BAD0 : (rf_addr == 4'd3) ? 32'h1234_5678 : {28'hC0DE000, rf_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        step; #1;
        chk("rst_awready", awready, 0); chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0); chk("rst_rvalid", rvalid, 0);
        chk("rst_rf_en", rf_en, 0); chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_addr", rf_addr, 0); chk("rst_rf_wr_data", rf_wr_data, 0);
        chk("rst_rdata", rdata, 0);
        step; resetn = 1;
        // basic write
        step; awaddr = 6'h08; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1; #1;
        chk("w1_awready", awready, 1); chk("w1_wready", wready, 1); chk("w1_arready", arready, 0);
        step; awvalid = 0; wvalid = 0; #1;
        chk("w1_rf_en", rf_en, 1); chk("w1_rf_addr", rf_addr, 2); chk("w1_rf_we", rf_we, 4'hF);
        chk("w1_rf_wr_data", rf_wr_data, 32'hDEAD_BEEF); chk("w1_bvalid_early", bvalid, 0);
        step; #1;
        chk("w1_rf_en_off", rf_en, 0); chk("w1_bvalid", bvalid, 1); chk("w1_bresp", bresp, 0);
        // basic read, accepted the cycle after the write completes
        step; araddr = 6'h0C; arvalid = 1; rready = 1; #1;
        chk("w1_bvalid_off", bvalid, 0); chk("r1_arready", arready, 1);
        step; arvalid = 0; #1;
        chk("r1_rf_en", rf_en, 1); chk("r1_rf_we", rf_we, 0); chk("r1_rf_addr", rf_addr, 3);
        step; #1;
        chk("r1_rf_en_off", rf_en, 0); chk("r1_rvalid_early", rvalid, 0);
        step; #1;
        chk("r1_rvalid", rvalid, 1); chk("r1_rdata", rdata, 32'h1234_5678); chk("r1_rresp", rresp, 0);
        // zero-strobe write with bready stalled while a read waits
        step; awaddr = 6'h14; wdata = 32'h0BAD_F00D; wstrb = 4'h0; awvalid = 1; wvalid = 1; bready = 0; #1;
        chk("r1_rvalid_off", rvalid, 0); chk("w0_awready", awready, 1);
        step; awvalid = 0; wvalid = 0; araddr = 6'h04; arvalid = 1; rready = 0; #1;
        chk("w0_rf_en", rf_en, 1); chk("w0_rf_we", rf_we, 4'h0); chk("w0_rf_addr", rf_addr, 5);
        chk("w0_arready_exec", arready, 0);
        for (int i = 0; i < 5; i++) begin
            step; #1;
            chk("bstall_bvalid", bvalid, 1); chk("bstall_arready", arready, 0); chk("bstall_rf_en", rf_en, 0);
        end
        bready = 1;
        // read accepted the cycle after bready completes, then rready stall
        step; #1;
        chk("bstall_done", bvalid, 0); chk("r2_arready", arready, 1);
        step; arvalid = 0; #1;
        chk("r2_rf_en", rf_en, 1); chk("r2_rf_addr", rf_addr, 1);
        step;
        for (int i = 0; i < 4; i++) begin
            step; #1;
            chk("rstall_rvalid", rvalid, 1); chk("rstall_rdata", rdata, 32'hC0DE_0001);
        end
        rready = 1;
        step; #1;
        chk("rstall_done", rvalid, 0);
        // arbitration after reset with all requests held: read, write, read
        resetn = 0; #1;
        chk("arb_rst_arready", arready, 0);
        step; resetn = 1;
        awaddr = 6'h3E; wdata = 32'h5555_AAAA; wstrb = 4'hF; araddr = 6'h1B;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1; #1;
        chk("arb1_arready", arready, 1); chk("arb1_awready", awready, 0);
        step; #1;
        chk("arb1_rf_addr", rf_addr, 6); chk("arb1_rf_we", rf_we, 0);
        step; step; #1;
        chk("arb1_rdata", rdata, 32'hC0DE_0006); chk("arb1_rvalid", rvalid, 1);
        step; #1;
        chk("arb2_awready", awready, 1); chk("arb2_arready", arready, 0);
        step; #1;
        chk("arb2_rf_addr", rf_addr, 4'hF); chk("arb2_rf_we", rf_we, 4'hF);
        step; #1;
        chk("arb2_bvalid", bvalid, 1);
        step; #1;
        chk("arb3_arready", arready, 1); chk("arb3_awready", awready, 0);
        // reset during RD_EXEC
        step; awvalid = 0; wvalid = 0; arvalid = 0; #1;
        chk("rdx_rf_en", rf_en, 1);
        resetn = 0; #1;
        chk("rdx_rst_rf_en", rf_en, 0); chk("rdx_rst_rf_we", rf_we, 0); chk("rdx_rst_rvalid", rvalid, 0);
        step; resetn = 1;
        // reset during WR_RESP
        step; awaddr = 6'h10; wdata = 32'h1111_2222; wstrb = 4'h3; awvalid = 1; wvalid = 1; bready = 0; #1;
        chk("wrr_awready", awready, 1);
        step; awvalid = 0; wvalid = 0; #1;
        chk("wrr_rf_we", rf_we, 4'h3);
        step; #1;
        chk("wrr_bvalid", bvalid, 1);
        resetn = 0; #1;
        chk("wrr_rst_bvalid", bvalid, 0); chk("wrr_rst_rf_en", rf_en, 0); chk("wrr_rst_rf_addr", rf_addr, 0);
        // recovery write after reset
        step; resetn = 1; bready = 1;
        awaddr = 6'h24; wdata = 32'hCAFE_F00D; wstrb = 4'hC; awvalid = 1; wvalid = 1; #1;
        chk("rec_awready", awready, 1);
        step; awvalid = 0; wvalid = 0; #1;
        chk("rec_rf_en", rf_en, 1); chk("rec_rf_addr", rf_addr, 9);
        chk("rec_rf_we", rf_we, 4'hC); chk("rec_rf_wr_data", rf_wr_data, 32'hCAFE_F00D);
        step; #1;
        chk("rec_bvalid", bvalid, 1);
        // address without data is never accepted
        step; awaddr = 6'h30; wdata = 32'h7777_8888; wstrb = 4'hF; awvalid = 1; wvalid = 0; #1;
        for (int i = 0; i < 10; i++) begin
            chk("aw_only_awready", awready, 0); chk("aw_only_wready", wready, 0); chk("aw_only_rf_en", rf_en, 0);
            step; #1;
        end
        wvalid = 1; #1;
        chk("aw_w_awready", awready, 1); chk("aw_w_wready", wready, 1);
        step; awvalid = 0; wvalid = 0; #1;
        chk("aw_w_rf_en", rf_en, 1); chk("aw_w_rf_addr", rf_addr, 4'hC);
        step; step;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axil_regfile_bridge.md
Name: axil_regfile_bridge

Overview:
- AXI4-Lite slave that converts MicroBlaze register accesses into the single-port BRAM-style strobe interface consumed by the register file (clk, addr, wr_data, rd_data, en, we).
- Sits directly upstream of the register file, in RTL outside the block diagram. The block diagram exports the AXI4-Lite port.
- Allows one outstanding transaction. Alternating priority between read and write. Always returns OKAY.

Parameters:
- Naddr, 4, register (word) address width; byte address width is Naddr+2.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- s_axi_awaddr  in  Naddr+2  write byte address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address accept
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data accept
- s_axi_bresp  out  2  always 2'b00
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response accept
- s_axi_araddr  in  Naddr+2  read byte address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address accept
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  always 2'b00
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data accept
- rf_addr  out  Naddr  register address to the register file (= byte addr[Naddr+1:2])
- rf_wr_data  out  32  write data to the register file
- rf_rd_data  in  32  register file read data, valid 1 cycle after rf_en
- rf_en  out  1  access strobe, exactly one cycle per transaction
- rf_we  out  4  byte write enables, qualified by rf_en

Behaviour:
- Clock is clk. Reset is resetn, asynchronous, active-low.
- Reset forces state IDLE and last_wr=1, so a read wins the first tie.
- Reset values: all ready/valid outputs 0, rf_en=0, rf_we=0, rf_addr=0, rf_wr_data=0, s_axi_rdata=0.
- States and transitions:
  - IDLE: write is pending when awvalid && wvalid (both required; either one alone is not accepted). Read is pending when arvalid.
    - Only one pending: select it.
    - Both pending: select read if last_wr=1, else write.
    - Write selected: awready=wready=1 combinationally in this cycle; latch addr, wdata, wstrb; go to WR_EXEC; last_wr<=1.
    - Read selected: arready=1 combinationally; latch addr; go to RD_EXEC; last_wr<=0.
    - Ready outputs are 0 in every other state.
  - WR_EXEC: rf_en=1, rf_we=latched wstrb, rf_addr and rf_wr_data driven. Next cycle WR_RESP.
  - WR_RESP: bvalid=1, held until bready, then IDLE.
  - RD_EXEC: rf_en=1, rf_we=0. Next cycle RD_WAIT.
  - RD_WAIT: capture rf_rd_data into s_axi_rdata. Next cycle RD_RESP.
  - RD_RESP: rvalid=1, rdata stable until rready, then IDLE.
- rf_en, rf_we, rf_addr and rf_wr_data are registered outputs. rf_en and rf_we are 0 outside the *_EXEC states.
- Latency, with acceptance at cycle T:
  - Write: rf_en at T+1, bvalid at T+2.
  - Read: rf_en at T+1, rvalid at T+3.
- wstrb=0: still issue the rf_en cycle with rf_we=0 and return OKAY.
- Upper address bits above Naddr+1 do not exist. Low 2 byte-address bits are ignored.
- A new transaction can be accepted no earlier than the cycle after bready/rready completes in IDLE. Minimum spacing is 3 cycles for writes and 4 cycles for reads.
- Reset mid-transaction: immediate return to IDLE, rf_en/rf_we drop asynchronously, no partial write, and the pending response is discarded.

Decomposition:
- Package regfile_bridge_pkg:
  - state_t enum {IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP}
  - localparam AXI_RESP_OKAY = 2'b00
- No sub-module. Arbitration is a single flag inside the FSM.

Test Plan:
- Write awaddr=0x08, wdata=0xDEADBEEF, wstrb=0xF -> rf_en=1 for one cycle with rf_addr=2, rf_we=0xF, rf_wr_data=0xDEADBEEF; bvalid two cycles after acceptance, bresp=0.
- Read araddr=0x0C with model rf_rd_data=0x12345678 one cycle after rf_en -> rvalid three cycles after arready, rdata=0x12345678, rresp=0.
- awvalid, wvalid and arvalid all held high after reset -> read, write, read accepted in that order; a write never takes two consecutive turns while a read is pending.
- awvalid high with wvalid low for 10 cycles -> no awready, no rf_en; wvalid rising -> both readys in the same cycle.
- bready held low for 5 cycles -> bvalid stays 1, no new acceptance; rready stall -> rdata unchanged until the handshake.
- resetn asserted during WR_RESP and during RD_EXEC -> all outputs 0 immediately, next access completes normally; wstrb=0x0 write -> rf_en pulse with rf_we=0.
